// File: rtl/line_buffer_pkg.sv
// Shared definitions for the line-buffer controller.
//   state_e         : controller FSM encoding
//   win_first()     : first row/column index at which a full window exists
//   fill_last_row() : last row that is only buffered, never windowed
package line_buffer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream,
    StDone
  } state_e;

  function automatic int unsigned win_first(input int unsigned window_size);
    return window_size - 1;
  endfunction

  function automatic int unsigned fill_last_row(input int unsigned window_size);
    return window_size - 2;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with enable and synchronous clear.
//   clk_i   : clock
//   clr_i   : synchronous clear, dominates en_i
//   en_i    : advance by one
//   count_o : current count, 0 .. Modulus-1
//   wrap_o  : en_i asserted while at Modulus-1 (count returns to 0 on this edge)
module wrap_counter #(
  parameter int unsigned Width   = 3,
  parameter int unsigned Modulus = 7
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [Width-1:0] Last = Width'(Modulus - 1);

  logic [Width-1:0] count_q, count_d;

  assign wrap_o  = en_i && (count_q == Last);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/line_buffer_controller.sv
// Raster-scan controller feeding a (WindowSize-1)-row line buffer and flagging
// pixels that complete a WindowSize x WindowSize window.
//   Clock, Reset        : clock, synchronous active-high reset
//   Start               : begins a frame (only honoured in idle)
//   PixelValid/PixelData: upstream binary pixel stream
//   PixelReady          : pixel accepted when PixelValid && PixelReady
//   LbWriteEnable/LbAddr/LbData : zero-latency line-buffer write port
//   Column, Row         : position of the next pixel to be accepted
//   WindowValid         : registered pulse after a window-completing pixel
//   FrameDone, Busy     : end-of-frame pulse, frame in progress
module line_buffer_controller
  import line_buffer_pkg::*;
#(
  parameter int unsigned AddrWidth   = 3,
  parameter int unsigned ImageWidth  = 7,
  parameter int unsigned WindowSize  = 3,
  parameter int unsigned ImageHeight = 5,
  parameter int unsigned RowWidth    = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 PixelValid,
  input  logic                 PixelData,
  output logic                 PixelReady,
  output logic                 LbWriteEnable,
  output logic [AddrWidth-1:0] LbAddr,
  output logic                 LbData,
  output logic [AddrWidth-1:0] Column,
  output logic [RowWidth-1:0]  Row,
  output logic                 WindowValid,
  output logic                 FrameDone,
  output logic                 Busy
);

  localparam logic [AddrWidth-1:0] WinCol      = AddrWidth'(win_first(WindowSize));
  localparam logic [RowWidth-1:0]  WinRow      = RowWidth'(win_first(WindowSize));
  localparam logic [RowWidth-1:0]  FillLastRow = RowWidth'(fill_last_row(WindowSize));

  state_e state_q;
  logic   accept;
  logic   cnt_clr;
  logic   col_wrap;
  logic   row_wrap;
  logic   window_q;

  assign PixelReady    = (state_q == StFill) || (state_q == StStream);
  // Reset blocks acceptance so nothing is written or counted in a reset cycle.
  assign accept        = PixelValid && PixelReady && !Reset;
  assign LbWriteEnable = accept;
  assign LbAddr        = Column;
  assign LbData        = PixelData;

  // Holding the counters clear in idle guarantees a frame starts at (0,0).
  assign cnt_clr = Reset || (state_q == StIdle);

  wrap_counter #(
    .Width   (AddrWidth),
    .Modulus (ImageWidth)
  ) u_col_cnt (
    .clk_i   (Clock),
    .clr_i   (cnt_clr),
    .en_i    (accept),
    .count_o (Column),
    .wrap_o  (col_wrap)
  );

  // row_wrap marks acceptance of the very last pixel of the frame.
  wrap_counter #(
    .Width   (RowWidth),
    .Modulus (ImageHeight)
  ) u_row_cnt (
    .clk_i   (Clock),
    .clr_i   (cnt_clr),
    .en_i    (col_wrap),
    .count_o (Row),
    .wrap_o  (row_wrap)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= StIdle;
      window_q <= 1'b0;
    end else begin
      window_q <= accept && (Row >= WinRow) && (Column >= WinCol);
      unique case (state_q)
        StIdle:   if (Start) state_q <= StFill;
        StFill:   if (col_wrap && (Row == FillLastRow)) state_q <= StStream;
        StStream: if (row_wrap) state_q <= StDone;
        StDone:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign WindowValid = window_q;
  assign FrameDone   = (state_q == StDone);
  assign Busy        = (state_q != StIdle);

endmodule

// File: tb/tb_line_buffer_controller.sv
module tb_line_buffer_controller;

  localparam int W  = 7;
  localparam int WS = 3;
  localparam int H  = 5;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       PixelValid = 1'b0;
  logic       PixelData = 1'b0;
  logic       PixelReady, LbWriteEnable, LbData, WindowValid, FrameDone, Busy;
  logic [2:0] LbAddr, Column;
  logic [2:0] Row;

  line_buffer_controller #(
    .AddrWidth   (3),
    .ImageWidth  (W),
    .WindowSize  (WS),
    .ImageHeight (H),
    .RowWidth    (3)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Start         (Start),
    .PixelValid    (PixelValid),
    .PixelData     (PixelData),
    .PixelReady    (PixelReady),
    .LbWriteEnable (LbWriteEnable),
    .LbAddr        (LbAddr),
    .LbData        (LbData),
    .Column        (Column),
    .Row           (Row),
    .WindowValid   (WindowValid),
    .FrameDone     (FrameDone),
    .Busy          (Busy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       we;
    logic       fd;
    logic [2:0] col;
    logic [2:0] row;
  } status_t;

  typedef struct packed {
    int         cyc;
    logic [2:0] addr;
    logic       data;
  } wr_t;

  status_t sq[$];
  wr_t     wq[$];
  int      vq[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 idle, 1 taking pixels, 2 frame-done cycle; idx = pixels taken.
  int mstate = 0;
  int idx    = 0;

  task automatic step(input logic st, input logic v, input logic d, input logic r);
    status_t e;
    wr_t     w;
    logic    acc;
    Start      = st;
    PixelValid = v;
    PixelData  = d;
    Reset      = r;
    acc     = (mstate == 1) && v && !r;
    e.ready = (mstate == 1);
    e.busy  = (mstate != 0);
    e.we    = acc;
    e.fd    = (mstate == 2);
    e.col   = 3'(idx % W);
    e.row   = 3'((idx / W) % H);
    sq.push_back(e);
    if (acc) begin
      w.cyc  = cyc;
      w.addr = e.col;
      w.data = d;
      wq.push_back(w);
      if ((idx / W) >= WS - 1 && (idx % W) >= WS - 1) vq.push_back(cyc + 1);
    end
    if (r) begin
      mstate = 0;
      idx    = 0;
    end else begin
      case (mstate)
        0: if (st) begin mstate = 1; idx = 0; end
        1: if (acc) begin
             idx = idx + 1;
             if (idx == W * H) mstate = 2;
           end
        default: mstate = 0;
      endcase
    end
    @(posedge Clock);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a cycle or an event.
  always @(negedge Clock) begin
    status_t s, got;
    wr_t     w;
    int      vc;
    if (sq.size() > 0) begin
      s   = sq.pop_front();
      got = {PixelReady, Busy, LbWriteEnable, FrameDone, Column, Row};
      n_checks++;
      if (got !== s) begin
        n_errors++;
        $display("FAIL status cyc=%0d got rdy/busy/we/fd/col/row=%b/%b/%b/%b/%0d/%0d exp=%b/%b/%b/%b/%0d/%0d",
                 cyc, got.ready, got.busy, got.we, got.fd, got.col, got.row,
                 s.ready, s.busy, s.we, s.fd, s.col, s.row);
      end
    end
    if (LbWriteEnable === 1'b1) begin
      n_checks++;
      if (wq.size() == 0) begin
        n_errors++;
        $display("FAIL write cyc=%0d got unexpected write addr=%0d exp none", cyc, LbAddr);
      end else begin
        w = wq.pop_front();
        if (w.cyc != cyc || LbAddr !== w.addr || LbData !== w.data) begin
          n_errors++;
          $display("FAIL write cyc=%0d got addr=%0d data=%b exp cyc=%0d addr=%0d data=%b",
                   cyc, LbAddr, LbData, w.cyc, w.addr, w.data);
        end
      end
    end
    if (WindowValid === 1'b1) begin
      n_checks++;
      if (vq.size() == 0) begin
        n_errors++;
        $display("FAIL window cyc=%0d got unexpected pulse exp none", cyc);
      end else begin
        vc = vq.pop_front();
        if (vc != cyc) begin
          n_errors++;
          $display("FAIL window got pulse cyc=%0d exp cyc=%0d", cyc, vc);
        end
      end
    end
    while (vq.size() > 0 && vq[0] < cyc) begin
      n_checks++;
      n_errors++;
      $display("FAIL window got no pulse exp cyc=%0d", vq[0]);
      vc = vq.pop_front();
    end
    while (wq.size() > 0 && wq[0].cyc < cyc) begin
      n_checks++;
      n_errors++;
      $display("FAIL write got no write exp cyc=%0d", wq[0].cyc);
      w = wq.pop_front();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    @(posedge Clock);
    #1;
    // Reset then idle
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);

    // First row back-to-back, then the rest of a full back-to-back frame
    step(1, 0, 0, 0);
    repeat (7) step(0, 1, 1'($urandom), 0);
    while (mstate == 1) step(0, 1, 1'($urandom), 0);
    repeat (3) step(0, 0, 0, 0);

    // Alternating PixelValid
    step(1, 0, 0, 0);
    k = 0;
    while (mstate == 1) begin
      step(0, (k % 2) == 0, 1'($urandom), 0);
      k++;
    end
    repeat (2) step(0, 0, 0, 0);

    // Reset mid-frame at row 2, column 4 with a pixel offered
    step(1, 0, 0, 0);
    while (idx != 2 * W + 4) step(0, 1, 1'($urandom), 0);
    step(0, 1, 1'($urandom), 1);
    repeat (2) step(0, 1, 1'($urandom), 0);

    // Start pulses mid-frame and in the done cycle are ignored
    step(1, 0, 0, 0);
    while (mstate == 1) step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 1'($urandom), 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    while (mstate == 1) step($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, 1'($urandom), 0);
    repeat (2) step(0, 0, 0, 0);

    // Random soak with occasional reset
    repeat (500) step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                      $urandom_range(0, 59) == 0);
    repeat (4) step(0, 0, 0, 0);

    n_checks++;
    if (wq.size() != 0) begin
      n_errors++;
      $display("FAIL write_drain got %0d pending exp 0", wq.size());
    end
    n_checks++;
    if (vq.size() != 0) begin
      n_errors++;
      $display("FAIL window_drain got %0d pending exp 0", vq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
